// File: rtl/tl_cmd_arbiter_if.sv
// Command-port bundle between the requesters and the traffic-light command
// arbiter. The arbiter uses the slave modport. The requester side (or a bench)
// uses the master modport.
interface tl_cmd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TYPE_W  = 3,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*TYPE_W-1:0] req_type_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      cmd_valid_o;
  logic [TYPE_W-1:0]         cmd_type_o;
  logic [DATA_W-1:0]         cmd_data_o;
  logic [2:0]                cmd_src_o;
  logic                      reject_o;
  logic                      busy_o;

  modport slave (
    input  req_valid_i, req_type_i, req_data_i,
    output req_ready_o, cmd_valid_o, cmd_type_o, cmd_data_o, cmd_src_o,
           reject_o, busy_o
  );

  modport master (
    output req_valid_i, req_type_i, req_data_i,
    input  req_ready_o, cmd_valid_o, cmd_type_o, cmd_data_o, cmd_src_o,
           reject_o, busy_o
  );
endinterface

// File: rtl/tl_cmd_arbiter.sv
// Traffic-light command arbiter: channel 0 has fixed priority. Channels
// 1..NUM_REQ-1 are served round-robin. Each issued command is followed by
// CMD_GAP_CYCLES idle cycles. Malformed commands are accepted and then dropped
// with a reject pulse.
// Optional build macro TL_ARB_PRIO_PREEMPT_EN: when defined, channel 0 may be
// granted during the gap, which cuts the remaining gap short.
module tl_cmd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CMD_GAP_CYCLES = 4,
  parameter int TYPE_W         = 3,
  parameter int DATA_W         = 16
) (
  input logic             clk_i,
  input logic             srst_i,
  tl_cmd_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (CMD_GAP_CYCLES > 0) ? $clog2(CMD_GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, REJECT, GAP} state_t;

  state_t             state, state_nxt;
  logic [2:0]         rr_last, rr_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic [2:0]         src_r;
  logic [TYPE_W-1:0]  type_r;
  logic [DATA_W-1:0]  data_r;

  logic               gnt_found;
  logic [2:0]         gnt_idx;
  logic [TYPE_W-1:0]  gnt_type;
  logic [DATA_W-1:0]  gnt_data;
  logic               gnt_legal;
  logic               take;
  logic [NUM_REQ-1:0] ready;
  int                 cand;
  logic [IDX_W-1:0]   cand_idx;

  // Types 0..2 are always valid. Types 3..5 carry a duration, and a zero
  // duration would underflow the light controller's timer. Types 6 and up are
  // undefined.
  function automatic logic cmd_legal(input logic [TYPE_W-1:0] t,
                                     input logic [DATA_W-1:0] d);
    int unsigned tv;
    tv = 32'(t);
    return (tv < 3) || ((tv < 6) && (d != '0));
  endfunction

  // Grant selection: channel 0 first. Otherwise, take the first valid channel
  // after rr_last among channels 1..NUM_REQ-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    if (bus.req_valid_i[0]) begin
      gnt_found = 1'b1;
    end else begin
      for (int o = 1; o < NUM_REQ; o++) begin
        cand = int'(rr_last) + o;
        if (cand > NUM_REQ - 1) cand = cand - (NUM_REQ - 1);
        cand_idx = IDX_W'(cand);
        if (!gnt_found && bus.req_valid_i[cand_idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = 3'(cand);
        end
      end
    end
  end

  // Route the granted requester's command to the legality check and the
  // output registers.
  always_comb begin
    gnt_type = '0;
    gnt_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (3'(k) == gnt_idx) begin
        gnt_type = bus.req_type_i[k*TYPE_W +: TYPE_W];
        gnt_data = bus.req_data_i[k*DATA_W +: DATA_W];
      end
    end
    gnt_legal = cmd_legal(gnt_type, gnt_data);
  end

  // Next-state logic, gap counting, and the combinational accept pulse.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_last;
    gap_nxt   = gap_cnt;
    take      = 1'b0;
    ready     = '0;
    case (state)
      IDLE: take = gnt_found;
      ISSUE: begin
        if (CMD_GAP_CYCLES > 0) begin
          state_nxt = GAP;
          gap_nxt   = GAP_W'(CMD_GAP_CYCLES);
        end else begin
          state_nxt = IDLE;
        end
      end
      REJECT: state_nxt = IDLE;
      GAP: begin
        if (gap_cnt <= GAP_W'(1)) state_nxt = IDLE;
        else                      gap_nxt   = gap_cnt - GAP_W'(1);
`ifdef TL_ARB_PRIO_PREEMPT_EN
        take = bus.req_valid_i[0];
`endif
      end
      default: state_nxt = IDLE;
    endcase
    // No accept while reset is held, so a waiting requester keeps its command
    // and is re-arbitrated afterwards.
    if (take && !srst_i) begin
      ready     = NUM_REQ'(1) << gnt_idx;
      state_nxt = gnt_legal ? ISSUE : REJECT;
      if (gnt_idx != 3'd0) rr_nxt = gnt_idx;
    end
  end

  // State, round-robin pointer, gap counter, and the registered command
  // outputs.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state   <= IDLE;
      rr_last <= 3'(NUM_REQ - 1);
      gap_cnt <= '0;
      src_r   <= '0;
      type_r  <= '0;
      data_r  <= '0;
    end else begin
      state   <= state_nxt;
      rr_last <= rr_nxt;
      gap_cnt <= gap_nxt;
      if (take) begin
        src_r <= gnt_idx;
        if (gnt_legal) begin
          type_r <= gnt_type;
          data_r <= gnt_data;
        end
      end
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.cmd_valid_o = (state == ISSUE);
  assign bus.reject_o    = (state == REJECT);
  assign bus.busy_o      = (state != IDLE);
  assign bus.cmd_type_o  = type_r;
  assign bus.cmd_data_o  = data_r;
  assign bus.cmd_src_o   = src_r;

endmodule

// File: tb/tb_tl_cmd_arbiter.sv
// Directed bench for tl_cmd_arbiter: reset state, round-robin order, channel-0
// priority, command filtering, gap spacing, reset during a command, optional
// channel-0 preemption, and a second instance built with a zero gap.
module tb_tl_cmd_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TYPE_W  = 3;
  localparam int DATA_W  = 16;
  localparam int GAP     = 4;

  logic clk  = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  tl_cmd_arbiter_if #(.NUM_REQ(NUM_REQ), .TYPE_W(TYPE_W), .DATA_W(DATA_W)) bus ();
  tl_cmd_arbiter_if #(.NUM_REQ(NUM_REQ), .TYPE_W(TYPE_W), .DATA_W(DATA_W)) bus0 ();

  tl_cmd_arbiter #(.NUM_REQ(NUM_REQ), .CMD_GAP_CYCLES(GAP), .TYPE_W(TYPE_W), .DATA_W(DATA_W))
    u_dut (.clk_i(clk), .srst_i(srst), .bus(bus.slave));

  tl_cmd_arbiter #(.NUM_REQ(NUM_REQ), .CMD_GAP_CYCLES(0), .TYPE_W(TYPE_W), .DATA_W(DATA_W))
    u_dut_nogap (.clk_i(clk), .srst_i(srst), .bus(bus0.slave));

  int n_chk = 0;
  int n_err = 0;
  int last_type = 0;
  int last_data = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input int t, input int d);
    logic [NUM_REQ*TYPE_W-1:0] tm;
    logic [NUM_REQ*DATA_W-1:0] dm;
    tm = {{(NUM_REQ*TYPE_W-TYPE_W){1'b0}}, {TYPE_W{1'b1}}} << (ch * TYPE_W);
    dm = {{(NUM_REQ*DATA_W-DATA_W){1'b0}}, {DATA_W{1'b1}}} << (ch * DATA_W);
    bus.req_valid_i = bus.req_valid_i | (NUM_REQ'(1) << ch);
    bus.req_type_i  = (bus.req_type_i & ~tm) | ((NUM_REQ*TYPE_W)'(t) << (ch * TYPE_W));
    bus.req_data_i  = (bus.req_data_i & ~dm) | ((NUM_REQ*DATA_W)'(d) << (ch * DATA_W));
  endtask

  task automatic clr_req(input int ch);
    bus.req_valid_i = bus.req_valid_i & ~(NUM_REQ'(1) << ch);
  endtask

  // Expect a grant of a legal command on ch now, then the issue cycle, the gap,
  // and a return to idle.
  task automatic issue_expect(input string tag, input int ch, input int t, input int d);
    #1;
    check_val({tag, " ready"}, 32'(bus.req_ready_o), 32'(1 << ch));
    tick();
    clr_req(ch);
    #1;
    check_val({tag, " cmd_valid"}, 32'(bus.cmd_valid_o), 1);
    check_val({tag, " src"},       32'(bus.cmd_src_o), 32'(ch));
    check_val({tag, " type"},      32'(bus.cmd_type_o), 32'(t));
    check_val({tag, " data"},      32'(bus.cmd_data_o), 32'(d));
    check_val({tag, " ready_issue"}, 32'(bus.req_ready_o), 0);
    last_type = t;
    last_data = d;
    for (int k = 0; k < GAP; k++) begin
      tick();
      check_val({tag, " gap_busy"},  32'(bus.busy_o), 1);
      check_val({tag, " gap_valid"}, 32'(bus.cmd_valid_o), 0);
      check_val({tag, " gap_ready"}, 32'(bus.req_ready_o), 0);
    end
    tick();
    check_val({tag, " idle"}, 32'(bus.busy_o), 0);
  endtask

  // Expect a grant on ch that is dropped: a reject pulse, outputs held, and
  // idle again after two cycles.
  task automatic reject_expect(input string tag, input int ch);
    #1;
    check_val({tag, " ready"}, 32'(bus.req_ready_o), 32'(1 << ch));
    tick();
    clr_req(ch);
    #1;
    check_val({tag, " reject"},    32'(bus.reject_o), 1);
    check_val({tag, " cmd_valid"}, 32'(bus.cmd_valid_o), 0);
    check_val({tag, " src"},       32'(bus.cmd_src_o), 32'(ch));
    check_val({tag, " type_hold"}, 32'(bus.cmd_type_o), 32'(last_type));
    check_val({tag, " data_hold"}, 32'(bus.cmd_data_o), 32'(last_data));
    check_val({tag, " busy"},      32'(bus.busy_o), 1);
    tick();
    check_val({tag, " reject_end"}, 32'(bus.reject_o), 0);
    check_val({tag, " idle"},       32'(bus.busy_o), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.req_valid_i  = '0;
    bus.req_type_i   = '0;
    bus.req_data_i   = '0;
    bus0.req_valid_i = '0;
    bus0.req_type_i  = '0;
    bus0.req_data_i  = '0;
    repeat (3) tick();

    check_val("rst cmd_valid", 32'(bus.cmd_valid_o), 0);
    check_val("rst type",      32'(bus.cmd_type_o), 0);
    check_val("rst data",      32'(bus.cmd_data_o), 0);
    check_val("rst src",       32'(bus.cmd_src_o), 0);
    check_val("rst reject",    32'(bus.reject_o), 0);
    check_val("rst busy",      32'(bus.busy_o), 0);
    check_val("rst ready",     32'(bus.req_ready_o), 0);
    srst = 1'b0;
    tick();

    // Round-robin from reset: 1, 2, 3, then 1 again.
    set_req(1, 0, 1);
    set_req(2, 1, 2);
    set_req(3, 2, 3);
    issue_expect("rr1", 1, 0, 1);
    set_req(1, 5, 9);
    issue_expect("rr2", 2, 1, 2);
    issue_expect("rr3", 3, 2, 3);
    issue_expect("rr4", 1, 5, 9);

    // Single request.
    set_req(2, 4, 30);
    issue_expect("single", 2, 4, 30);

    // Channel 0 wins, and the round-robin pointer (2) is untouched by it.
    set_req(0, 2, 7);
    set_req(1, 0, 11);
    set_req(3, 5, 100);
    issue_expect("prio0", 0, 2, 7);
    issue_expect("prio3", 3, 5, 100);
    issue_expect("prio1", 1, 0, 11);

    // Filtering, including back-to-back rejects.
    set_req(1, 3, 0);
    reject_expect("rej_t3d0", 1);
    set_req(2, 7, 55);
    reject_expect("rej_t7", 2);
    set_req(3, 6, 1);
    reject_expect("rej_t6", 3);
    set_req(3, 1, 0);
    issue_expect("t1_d0", 3, 1, 0);

    // Channel 0 arrives two cycles into the gap.
    set_req(2, 0, 44);
    #1;
    check_val("pre ready2", 32'(bus.req_ready_o), 32'(4));
    tick();
    clr_req(2);
    #1;
    check_val("pre issue2", 32'(bus.cmd_valid_o), 1);
    tick();
    tick();
    set_req(0, 4, 77);
    #1;
`ifdef TL_ARB_PRIO_PREEMPT_EN
    check_val("pre ready0_gap", 32'(bus.req_ready_o), 32'(1));
`else
    check_val("pre ready0_gap", 32'(bus.req_ready_o), 0);
    tick();
    check_val("pre ready0_gap3", 32'(bus.req_ready_o), 0);
    tick();
    check_val("pre ready0_gap4", 32'(bus.req_ready_o), 0);
    tick();
    check_val("pre ready0_idle", 32'(bus.req_ready_o), 32'(1));
`endif
    tick();
    clr_req(0);
    #1;
    check_val("pre issue0 valid", 32'(bus.cmd_valid_o), 1);
    check_val("pre issue0 src",   32'(bus.cmd_src_o), 0);
    check_val("pre issue0 data",  32'(bus.cmd_data_o), 32'(77));
    repeat (GAP) tick();
    tick();
    check_val("pre idle", 32'(bus.busy_o), 0);

    // Reset in the cycle after a grant of channel 2 (pointer 2 -> 2).
    set_req(2, 2, 5);
    #1;
    check_val("mrst ready2", 32'(bus.req_ready_o), 32'(4));
    tick();
    clr_req(2);
    set_req(1, 0, 1);
    set_req(3, 0, 3);
    srst = 1'b1;
    #1;
    check_val("mrst issue", 32'(bus.cmd_valid_o), 1);
    tick();
    check_val("mrst cmd_valid", 32'(bus.cmd_valid_o), 0);
    check_val("mrst busy",      32'(bus.busy_o), 0);
    check_val("mrst src",       32'(bus.cmd_src_o), 0);
    check_val("mrst data",      32'(bus.cmd_data_o), 0);
    check_val("mrst ready",     32'(bus.req_ready_o), 0);
    srst = 1'b0;
    set_req(2, 0, 2);
    issue_expect("post_rst", 1, 0, 1);
    bus.req_valid_i = '0;

    // Zero-gap instance: one legal command every two cycles.
    bus0.req_type_i  = {3'd0, 3'd4, 3'd1, 3'd0};
    bus0.req_data_i  = {16'd0, 16'd20, 16'd10, 16'd0};
    bus0.req_valid_i = 4'b0110;
    #1;
    check_val("g0 ready1", 32'(bus0.req_ready_o), 32'(2));
    tick();
    bus0.req_valid_i = 4'b0100;
    #1;
    check_val("g0 issue1 valid", 32'(bus0.cmd_valid_o), 1);
    check_val("g0 issue1 src",   32'(bus0.cmd_src_o), 1);
    check_val("g0 issue1 data",  32'(bus0.cmd_data_o), 32'(10));
    tick();
    check_val("g0 idle1",   32'(bus0.busy_o), 0);
    check_val("g0 ready2",  32'(bus0.req_ready_o), 32'(4));
    tick();
    bus0.req_valid_i = 4'b0000;
    #1;
    check_val("g0 issue2 valid", 32'(bus0.cmd_valid_o), 1);
    check_val("g0 issue2 src",   32'(bus0.cmd_src_o), 2);
    check_val("g0 issue2 type",  32'(bus0.cmd_type_o), 4);
    tick();
    check_val("g0 idle2", 32'(bus0.busy_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
